sha256_dout_collector: RTL and testbench

Parametrised multi-channel digest collector for the SHA256 output path. It captures 256-bit (DIGEST_W) digest pulses from NUM_CH hash cores, such as the message-expansion core and the main sha256 core, and arbitrates them round-robin into a shared FIFO. It then serialises each digest into OUT_W-bit beats on a valid/ready stream toward the bus or testbench monitor. It replaces the single fixed dout_vld/dout pair with a buffered, back-pressurable, channel-tagged output.

---
 rtl/sha256_dout_collector_if.sv | 32 +++
 rtl/sha256_dout_collector.sv | 161 ++++++++++++++++
 tb/tb_sha256_dout_collector.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_dout_collector_if.sv
// Digest collector bus: per-channel digest strobes in, tagged OUT_W-bit beat stream out.
// master = producer/sink side, slave = collector side.
interface sha256_dout_collector_if #(
   parameter int NUM_CH   = 2,
   parameter int DIGEST_W = 256,
   parameter int OUT_W    = 32,
   parameter int DEPTH    = 4
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [NUM_CH-1:0]          ch_dout_vld;
   logic [NUM_CH*DIGEST_W-1:0] ch_dout;
   logic                       out_vld;
   logic                       out_rdy;
   logic [OUT_W-1:0]           out_data;
   logic [CH_W-1:0]            out_ch;
   logic                       out_last;
   logic [NUM_CH-1:0]          ovf;
   logic                       ovf_clr;
   logic [LVL_W-1:0]           fifo_level;

   modport master (
      output ch_dout_vld, ch_dout, out_rdy, ovf_clr,
      input  out_vld, out_data, out_ch, out_last, ovf, fifo_level
   );

   modport slave (
      input  ch_dout_vld, ch_dout, out_rdy, ovf_clr,
      output out_vld, out_data, out_ch, out_last, ovf, fifo_level
   );
endinterface

// File: rtl/sha256_dout_collector.sv
// Captures NUM_CH digest strobes, round-robins them into a FIFO and serialises them MSB-beat-first.
// Define SHA256_DOUT_BYTESWAP_EN to byte-reverse every output beat for little-endian sinks.
module sha256_dout_collector #(
   parameter int NUM_CH   = 2,
   parameter int DIGEST_W = 256,
   parameter int OUT_W    = 32,
   parameter int DEPTH    = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   sha256_dout_collector_if.slave bus
);
   localparam int BEATS = DIGEST_W / OUT_W;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ENT_W = CH_W + DIGEST_W;

   // state  | meaning
   // S_IDLE | no digest loaded, waiting for FIFO entry
   // S_SEND | shifting out beats of loaded digest
   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic [DIGEST_W-1:0] r_hold [NUM_CH];
   logic [NUM_CH-1:0]   r_pend;
   logic [NUM_CH-1:0]   r_ovf;
   logic [CH_W-1:0]     r_rr;
   logic [ENT_W-1:0]    r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wp;
   logic [PTR_W-1:0]    r_rp;
   logic [LVL_W-1:0]    r_level;
   state_t              r_state;
   logic [DIGEST_W-1:0] r_shift;
   logic [CNT_W-1:0]    r_cnt;
   logic [CH_W-1:0]     r_ch;
   logic                r_vld;
   logic                r_last;

   logic                w_empty;
   logic                w_full;
   logic                w_accept;
   logic                w_pop;
   logic                w_push;
   logic                w_gnt_vld;
   logic [CH_W-1:0]     w_gnt_ch;
   logic [NUM_CH-1:0]   w_gnt_oh;
   logic [NUM_CH-1:0]   w_store;
   logic [NUM_CH-1:0]   w_drop;
   logic [ENT_W-1:0]    w_head;
   logic [OUT_W-1:0]    w_beat;

   function automatic logic [CH_W-1:0] f_rr_idx(input logic [CH_W-1:0] base, input int off);
      return CH_W'((int'(base) + off) % NUM_CH);
   endfunction

   assign w_empty  = (r_level == '0);
   assign w_full   = (r_level == LVL_W'(DEPTH));
   assign w_accept = r_vld && bus.out_rdy;
   // The serialiser loads whenever it is idle or its last beat leaves, so a pop frees a slot this cycle.
   assign w_pop    = !w_empty && ((r_state == S_IDLE) || (w_accept && r_last));
   assign w_push   = w_gnt_vld && (!w_full || w_pop);
   assign w_head   = r_mem[r_rp];

   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_ch  = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (r_pend[f_rr_idx(r_rr, k)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = f_rr_idx(r_rr, k);
         end
      end
   end

   always_comb begin
      w_gnt_oh = '0;
      w_store  = '0;
      w_drop   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_gnt_oh[i] = w_push && (w_gnt_ch == CH_W'(i));
         w_store[i]  = bus.ch_dout_vld[i] && (!r_pend[i] || w_gnt_oh[i]);
         w_drop[i]   = bus.ch_dout_vld[i] && !w_store[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend  <= '0;
         r_ovf   <= '0;
         r_rr    <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         r_pend <= (r_pend & ~w_gnt_oh) | w_store;
         r_ovf  <= (r_ovf & ~{NUM_CH{bus.ovf_clr}}) | w_drop;
         if (w_push) begin
            r_rr <= f_rr_idx(w_gnt_ch, 1);
            r_wp <= r_wp + PTR_W'(1);
         end
         if (w_pop) r_rp <= r_rp + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_store[i]) r_hold[i] <= bus.ch_dout[i*DIGEST_W +: DIGEST_W];
      end
      if (w_push) r_mem[r_wp] <= {w_gnt_ch, r_hold[w_gnt_ch]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_ch    <= '0;
         r_vld   <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_pop) begin
         r_state <= S_SEND;
         r_shift <= w_head[DIGEST_W-1:0];
         r_ch    <= w_head[ENT_W-1 -: CH_W];
         r_cnt   <= '0;
         r_vld   <= 1'b1;
         r_last  <= (BEATS == 1);
      end else if (w_accept) begin
         if (r_last) begin
            r_state <= S_IDLE;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
         end else begin
            r_shift <= r_shift << OUT_W;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_last  <= (int'(r_cnt) + 2 == BEATS);
         end
      end
   end

   always_comb begin
      w_beat = r_shift[DIGEST_W-1 -: OUT_W];
`ifdef SHA256_DOUT_BYTESWAP_EN
      for (int b = 0; b < OUT_W / 8; b++) begin
         w_beat[b*8 +: 8] = r_shift[DIGEST_W-1-b*8 -: 8];
      end
`endif
   end

   assign bus.out_vld    = r_vld;
   assign bus.out_data   = w_beat;
   assign bus.out_ch     = r_ch;
   assign bus.out_last   = r_last;
   assign bus.ovf        = r_ovf;
   assign bus.fifo_level = r_level;
endmodule

// File: tb/tb_sha256_dout_collector.sv
// Directed bench for sha256_dout_collector: latency, ordering, stalls, overflow and reset.
module tb_sha256_dout_collector;
   localparam int NUM_CH   = 2;
   localparam int DIGEST_W = 256;
   localparam int OUT_W    = 32;
   localparam int DEPTH    = 4;
   localparam int BEATS    = DIGEST_W / OUT_W;

   localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_EMP = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_C   = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210;
   localparam logic [255:0] D_D   = 256'hdeadbeef_cafef00d_0badc0de_feedface_13572468_24681357_a5a5a5a5_5a5a5a5a;
   localparam logic [255:0] D_E   = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
`ifdef SHA256_DOUT_BYTESWAP_EN
   localparam logic [31:0] ABC_FIRST = 32'hbf1678ba;
   localparam logic [31:0] ABC_LAST  = 32'had1500f2;
`else
   localparam logic [31:0] ABC_FIRST = 32'hba7816bf;
   localparam logic [31:0] ABC_LAST  = 32'hf20015ad;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha256_dout_collector_if #(.NUM_CH(NUM_CH), .DIGEST_W(DIGEST_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

   sha256_dout_collector #(.NUM_CH(NUM_CH), .DIGEST_W(DIGEST_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic logic [31:0] exp_beat(input logic [255:0] d, input int k);
      logic [31:0] b;
      b = d[255-32*k -: 32];
`ifdef SHA256_DOUT_BYTESWAP_EN
      b = {b[7:0], b[15:8], b[23:16], b[31:24]};
`endif
      return b;
   endfunction

   function automatic logic [255:0] mk(input int k);
      logic [31:0] w;
      w = 32'(k);
      return D_ABC ^ {8{w}};
   endfunction

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   logic [31:0] q_data [$];
   logic        q_ch   [$];
   logic        q_last [$];
   int unsigned q_cyc  [$];
   logic        p_stall = 1'b0;
   logic [31:0] p_data;
   logic        p_ch;
   logic        p_last;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_stall = 1'b0;
      end else begin
         if (p_stall) begin
            chk("stall_vld",  bus.out_vld,  1'b1);
            chk("stall_data", bus.out_data, p_data);
            chk("stall_ch",   bus.out_ch,   p_ch);
            chk("stall_last", bus.out_last, p_last);
         end
         if (bus.out_vld && bus.out_rdy) begin
            q_data.push_back(bus.out_data);
            q_ch.push_back(bus.out_ch);
            q_last.push_back(bus.out_last);
            q_cyc.push_back(cyc);
         end
         p_stall = bus.out_vld && !bus.out_rdy;
         p_data  = bus.out_data;
         p_ch    = bus.out_ch;
         p_last  = bus.out_last;
      end
   end

   task automatic clear_q();
      q_data.delete();
      q_ch.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just after a rising edge; the strobe is sampled on the next edge.
   task automatic strobe(input logic [1:0] m, input logic [255:0] d0, input logic [255:0] d1, input logic clr);
      bus.ch_dout_vld = m;
      bus.ch_dout     = {d1, d0};
      bus.ovf_clr     = clr;
      @(posedge clk);
      #1;
      bus.ch_dout_vld = '0;
      bus.ovf_clr     = 1'b0;
   endtask

   task automatic do_reset();
      bus.ch_dout_vld = '0;
      bus.ovf_clr     = 1'b0;
      bus.out_rdy     = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_q();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(input string tag, input int n, input int budget);
      int c;
      c = 0;
      while (q_data.size() < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk(tag, q_data.size(), n);
   endtask

   task automatic check_digest(input string tag, input logic ch, input logic [255:0] d);
      for (int k = 0; k < BEATS; k++) begin
         if (q_data.size() == 0) begin
            chk($sformatf("%s_missing_b%0d", tag, k), 0, 1);
            return;
         end
         chk($sformatf("%s_data_b%0d", tag, k), q_data.pop_front(), exp_beat(d, k));
         chk($sformatf("%s_ch_b%0d", tag, k), q_ch.pop_front(), ch);
         chk($sformatf("%s_last_b%0d", tag, k), q_last.pop_front(), (k == BEATS - 1));
         void'(q_cyc.pop_front());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.ch_dout_vld = '0;
      bus.ch_dout     = '0;
      bus.out_rdy     = 1'b0;
      bus.ovf_clr     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld",   bus.out_vld,    1'b0);
      chk("rst_data",  bus.out_data,   32'h0);
      chk("rst_ch",    bus.out_ch,     1'b0);
      chk("rst_last",  bus.out_last,   1'b0);
      chk("rst_ovf",   bus.ovf,        2'b00);
      chk("rst_level", bus.fifo_level, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single "abc" digest, 3-edge latency
      bus.out_rdy = 1'b1;
      strobe(2'b01, D_ABC, '0, 1'b0);
      @(negedge clk);
      chk("lat_e0_vld", bus.out_vld, 1'b0);
      @(negedge clk);
      chk("lat_e1_vld", bus.out_vld, 1'b0);
      @(negedge clk);
      chk("lat_e2_vld", bus.out_vld, 1'b1);
      chk("lat_e2_data", bus.out_data, ABC_FIRST);
      chk("lat_e2_ch", bus.out_ch, 1'b0);
      wait_beats("abc_beats", BEATS, 40);
      chk("abc_first", q_data[0], ABC_FIRST);
      chk("abc_last", q_data[BEATS-1], ABC_LAST);
      check_digest("abc", 1'b0, D_ABC);

      // simultaneous ch0/ch1 strobes, back-to-back output
      do_reset();
      bus.out_rdy = 1'b1;
      strobe(2'b11, D_ABC, D_EMP, 1'b0);
      wait_beats("dual_beats", 2 * BEATS, 60);
      chk("dual_no_bubble", q_cyc[2*BEATS-1] - q_cyc[0], 2 * BEATS - 1);
      chk("dual_ovf", bus.ovf, 2'b00);
      check_digest("dual0", 1'b0, D_ABC);
      check_digest("dual1", 1'b1, D_EMP);

      // random back-pressure over 3 digests
      do_reset();
      strobe(2'b01, D_C, '0, 1'b0);
      idle(1);
      strobe(2'b10, '0, D_D, 1'b0);
      idle(1);
      strobe(2'b01, D_E, '0, 1'b0);
      idle(1);
      begin
         int c;
         c = 0;
         while (q_data.size() < 3 * BEATS && c < 400) begin
            bus.out_rdy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            c++;
         end
      end
      bus.out_rdy = 1'b1;
      wait_beats("rnd_beats", 3 * BEATS, 40);
      check_digest("rnd0", 1'b0, D_C);
      check_digest("rnd1", 1'b1, D_D);
      check_digest("rnd2", 1'b0, D_E);

      // overflow on ch1 with the sink stalled
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         strobe(2'b10, '0, mk(k), 1'b0);
         idle(1);
      end
      idle(2);
      chk("cap6_ovf", bus.ovf, 2'b00);
      chk("cap6_level", bus.fifo_level, 3'd4);
      strobe(2'b10, '0, mk(7), 1'b0);
      idle(1);
      chk("drop7_ovf", bus.ovf, 2'b10);
      chk("drop7_level", bus.fifo_level, 3'd4);
      bus.out_rdy = 1'b1;
      wait_beats("ovf_beats", 6 * BEATS, 150);
      for (int k = 1; k <= 6; k++) check_digest($sformatf("ovf_d%0d", k), 1'b1, mk(k));
      chk("ovf_sticky", bus.ovf, 2'b10);
      strobe(2'b00, '0, '0, 1'b1);
      @(negedge clk);
      chk("ovf_cleared", bus.ovf, 2'b00);
      @(posedge clk);
      #1;
      bus.out_rdy = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         strobe(2'b10, '0, mk(k + 30), 1'b0);
         idle(1);
      end
      idle(2);
      strobe(2'b10, '0, mk(40), 1'b1);
      @(negedge clk);
      chk("ovf_set_beats_clr", bus.ovf, 2'b10);

      // asynchronous reset mid-digest with entries queued
      do_reset();
      strobe(2'b10, '0, mk(11), 1'b0);
      idle(1);
      strobe(2'b10, '0, mk(12), 1'b0);
      idle(1);
      strobe(2'b10, '0, mk(13), 1'b0);
      idle(3);
      chk("mid_level", bus.fifo_level, 3'd2);
      bus.out_rdy = 1'b1;
      idle(3);
      bus.out_rdy = 1'b0;
      @(negedge clk);
      chk("mid_beats", q_data.size(), 3);
      chk("mid_ch", bus.out_ch, 1'b1);
      chk("mid_data", bus.out_data, exp_beat(mk(11), 3));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld",   bus.out_vld,    1'b0);
      chk("arst_data",  bus.out_data,   32'h0);
      chk("arst_ch",    bus.out_ch,     1'b0);
      chk("arst_last",  bus.out_last,   1'b0);
      chk("arst_ovf",   bus.ovf,        2'b00);
      chk("arst_level", bus.fifo_level, 3'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_q();
      @(posedge clk);
      #1;
      bus.out_rdy = 1'b1;
      strobe(2'b01, mk(20), '0, 1'b0);
      wait_beats("post_rst_beats", BEATS, 40);
      check_digest("post_rst", 1'b0, mk(20));
      idle(20);
      chk("post_rst_no_stale", q_data.size(), 0);
      chk("post_rst_idle", bus.out_vld, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
